// File: rtl/grf_mp.sv
// grf_mp: multi-port general register file with write bypass and pending scoreboard.
// DEPTH x DW words, NR combinational read ports, one synchronous write port.
//
// Parameters:
//   DW      data width
//   DEPTH   number of registers (2..32)
//   AW      address width, DEPTH <= 2**AW
//   NR      number of read ports (1..4)
//   BYPASS  1 = same-cycle write data forwarded to matching reads
//   GP_INIT reset value of register 28
//   SP_INIT reset value of register 29
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   raddr / rdata       NR packed read addresses / read data
//   rpend               per-port "register has an outstanding producer"
//   we, waddr, wdata    write port (WB stage)
//   pc                  PC of the writer, only used by the trace
//   issue_en/issue_addr mark a register pending (issue point)
//
// Optional feature: define GRF_TRACE_EN to print every accepted write
// as "@<pc>: $<reg> <= <data>".

module grf_mp #(
    parameter int DW = 32,
    parameter int DEPTH = 32,
    parameter int AW = 5,
    parameter int NR = 2,
    parameter int BYPASS = 1,
    parameter logic [DW-1:0] GP_INIT = 32'h00001800,
    parameter logic [DW-1:0] SP_INIT = 32'h00000ffc
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NR*AW-1:0] raddr,
    output logic [NR*DW-1:0] rdata,
    output logic [NR-1:0]   rpend,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [DW-1:0]   wdata,
    input  logic [31:0]     pc,
    input  logic            issue_en,
    input  logic [AW-1:0]   issue_addr
);

    // Array index width; out-of-range addresses are always gated by in_range.
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [DW-1:0]    mem_q [DEPTH];
    logic [DW-1:0]    mem_d [DEPTH];
    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;

    logic wr_ok;
    logic iss_ok;

    // Register 0 and addresses beyond DEPTH hold nothing.
    function automatic logic in_range(input logic [AW-1:0] a);
        return (a != '0) && ({1'b0, a} < DEPTH_W);
    endfunction

    function automatic logic [DW-1:0] init_val(input int idx);
        logic [DW-1:0] v;
        v = '0;
        if (idx == 28) v = GP_INIT;
        if (idx == 29) v = SP_INIT;
        return v;
    endfunction

    assign wr_ok  = we && in_range(waddr);
    assign iss_ok = issue_en && in_range(issue_addr);

    // Next state. Issue is applied after the write clear so a newer
    // producer issued on the same edge keeps the bit set.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        pend_d = pend_q;
        if (wr_ok) begin
            mem_d[waddr[IW-1:0]]  = wdata;
            pend_d[waddr[IW-1:0]] = 1'b0;
        end
        if (iss_ok) begin
            pend_d[issue_addr[IW-1:0]] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= init_val(i);
            end
            pend_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            pend_q <= pend_d;
        end
    end

    // Read ports: purely combinational, fully independent.
    for (genvar k = 0; k < NR; k++) begin : g_rd
        logic [AW-1:0] ra;
        logic          ok;
        logic          hit;

        assign ra  = raddr[k*AW +: AW];
        assign ok  = in_range(ra);
        assign hit = (BYPASS != 0) && we && (ra == waddr) && ok;

        assign rdata[k*DW +: DW] = hit ? wdata :
                                   ok  ? mem_q[ra[IW-1:0]] : '0;

        // Not masked by the bypass: the hazard unit does its own forwarding.
        assign rpend[k] = ok && pend_q[ra[IW-1:0]];
    end

`ifdef GRF_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset && wr_ok) begin
            $display("@%h: $%d <= %h", pc, waddr, wdata);
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^pc;
`endif

endmodule
